id_stage: RTL and testbench
===========================

ID_STAGE -- requirements
Module: id_stage

Interface
REQ-001 Parameter: NOP_INSTR, 32'h00000013, instruction word presented on instr_o when valid_o=0.
REQ-002 clk_i  input  1  single clock; all state on rising edge.
REQ-003 rst_i  input  1  reset, asynchronous, active-high.
REQ-004 pc_i  input  32  PC of fetched instruction from fetch stage.
REQ-005 instr_i  input  32  fetched instruction word.
REQ-006 valid_i  input  1  pc_i/instr_i valid this cycle.
REQ-007 stall_o  output  1  to fetch stall_i; hold fetch PC/instruction.
REQ-008 flush_o  output  1  to fetch flush_i; discard in-flight fetch.
REQ-009 pc_b_j_o  output  32  to fetch pc_b_j_i; redirect target.
REQ-010 take_b_j_sig_o  output  1  to fetch take_b_j_sig_i; redirect strobe.
REQ-011 ex_ready_i  input  1  execute stage accepts the decode register this cycle.
REQ-012 ex_mem_read_i  input  1  instruction in execute is a load.
REQ-013 ex_rd_i  input  5  destination register of instruction in execute.
REQ-014 ex_take_b_j_i  input  1  execute resolved a taken branch/jump.
REQ-015 ex_pc_b_j_i  input  32  execute-resolved target.
REQ-016 valid_o, pc_o[32], instr_o[32], opcode_o[7], funct3_o[3], funct7_o[7], rd_o[5], rs1_o[5], rs2_o[5], imm_o[32]  outputs  registered decode register to execute.

Function
REQ-017 Decode register loads decoded valid_i instruction at clock edge when state RUN, ex_ready_i=1, no hazard, no redirect; latency one cycle.
REQ-018 imm_o shall be sign-extended to 32 bits per I/S/B/U/J format selected by opcode; R-type imm_o=0.
REQ-019 Load-use hazard: valid_i & ex_mem_read_i & ex_rd_i!=0 & (ex_rd_i==rs1 used, or ex_rd_i==rs2 used by R/S/B) -> stall_o=1 combinationally, decode register loads bubble (valid_o=0, instr_o=NOP_INSTR).
REQ-020 ex_ready_i=0 -> stall_o=1, decode register holds all fields unchanged.
REQ-021 ex_take_b_j_i=1 -> same cycle take_b_j_sig_o=1, pc_b_j_o=ex_pc_b_j_i, flush_o=1, stall_o=0; decode register loads bubble; highest priority over hazard, backpressure and early jump.
REQ-022 FSM states RUN, KILL; any redirect (REQ-021 or REQ-026) -> KILL next cycle; KILL ignores valid_i (bubble loaded), returns to RUN after one cycle unless a new redirect occurs.
REQ-023 No redirect: take_b_j_sig_o=0, flush_o=0, pc_b_j_o=0.
REQ-024 pc arithmetic modulo 2^32; wrap from 0xFFFFFFFC is legal.

Reset
REQ-025 rst_i asserted: immediately valid_o=0, instr_o=NOP_INSTR, all other registered fields 0, state RUN; stall_o, flush_o, take_b_j_sig_o, pc_b_j_o forced 0 while rst_i=1; reset mid-redirect discards KILL.

Configuration
REQ-026 ID_EARLY_JAL_EN defined: valid JAL in RUN with no hazard, ex_ready_i=1, no EX redirect -> same cycle take_b_j_sig_o=1, flush_o=1, pc_b_j_o=pc_i+imm_J; JAL still issues with valid_o=1. Undefined: no early redirect, JAL resolved only by execute.

Structure
REQ-027 Shared package id_pkg: opcode constants, NOP_INSTR default, FSM state enum, decode-field widths.
REQ-028 Immediate generation in sub-module imm_gen (combinational, instr in, imm out).

Verification
REQ-029 rst_i pulse mid-stream -> valid_o=0, instr_o=0x00000013, stall_o=0 without waiting for clock edge.
REQ-030 pc_i=0x0, instr_i=0x00500093 -> next cycle valid_o=1, pc_o=0x0, rd_o=1, rs1_o=0, imm_o=5.
REQ-031 ex_mem_read_i=1, ex_rd_i=1, instr_i=0x00108133 -> stall_o=1, valid_o=0 next; drop ex_mem_read_i -> add issues next cycle, rd_o=2.
REQ-032 ex_take_b_j_i=1, ex_pc_b_j_i=0x40 -> same cycle take_b_j_sig_o=1, flush_o=1, pc_b_j_o=0x40; following valid_i ignored, valid_o=0 two cycles.
REQ-033 ID_EARLY_JAL_EN on, pc_i=0x8, instr_i=0x010000EF -> pc_b_j_o=0x18 same cycle, valid_o=1 rd_o=1 next; macro off -> take_b_j_sig_o=0.
REQ-034 ex_ready_i=0 for 3 cycles with valid instruction held -> stall_o=1, all outputs stable; release -> next instruction loads.

Source files
------------

// File: rtl/id_pkg.sv
// Shared decode definitions for the instruction-decode stage: opcodes, widths,
// FSM state, decode-register layout and operand-usage helpers.
package id_pkg;

  localparam int XLEN  = 32;
  localparam int REG_W = 5;
  localparam int OPC_W = 7;
  localparam int F3_W  = 3;
  localparam int F7_W  = 7;

  localparam logic [XLEN-1:0] NOP_INSTR_DEFAULT = 32'h00000013;

  localparam logic [OPC_W-1:0] OPC_LOAD   = 7'b0000011;
  localparam logic [OPC_W-1:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [OPC_W-1:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [OPC_W-1:0] OPC_STORE  = 7'b0100011;
  localparam logic [OPC_W-1:0] OPC_OP     = 7'b0110011;
  localparam logic [OPC_W-1:0] OPC_LUI    = 7'b0110111;
  localparam logic [OPC_W-1:0] OPC_BRANCH = 7'b1100011;
  localparam logic [OPC_W-1:0] OPC_JALR   = 7'b1100111;
  localparam logic [OPC_W-1:0] OPC_JAL    = 7'b1101111;
  localparam logic [OPC_W-1:0] OPC_SYSTEM = 7'b1110011;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_KILL = 1'b1
  } id_state_e;

  typedef enum logic [2:0] {
    FMT_NONE,
    FMT_I,
    FMT_S,
    FMT_B,
    FMT_U,
    FMT_J
  } imm_fmt_e;

  typedef struct packed {
    logic             valid;
    logic [XLEN-1:0]  pc;
    logic [XLEN-1:0]  instr;
    logic [OPC_W-1:0] opcode;
    logic [F3_W-1:0]  funct3;
    logic [F7_W-1:0]  funct7;
    logic [REG_W-1:0] rd;
    logic [REG_W-1:0] rs1;
    logic [REG_W-1:0] rs2;
    logic [XLEN-1:0]  imm;
  } dec_t;

  function automatic imm_fmt_e fmt_of(input logic [OPC_W-1:0] opc);
    imm_fmt_e fmt;
    fmt = FMT_NONE;
    case (opc)
      OPC_LOAD, OPC_OP_IMM, OPC_JALR, OPC_SYSTEM: fmt = FMT_I;
      OPC_STORE:                                  fmt = FMT_S;
      OPC_BRANCH:                                 fmt = FMT_B;
      OPC_LUI, OPC_AUIPC:                         fmt = FMT_U;
      OPC_JAL:                                    fmt = FMT_J;
      default:                                    fmt = FMT_NONE;
    endcase
    return fmt;
  endfunction

  // Only real source-register reads may create a load-use stall.
  function automatic logic uses_rs1(input logic [OPC_W-1:0] opc);
    return (opc == OPC_LOAD)  || (opc == OPC_OP_IMM) || (opc == OPC_STORE) ||
           (opc == OPC_OP)    || (opc == OPC_BRANCH) || (opc == OPC_JALR)  ||
           (opc == OPC_SYSTEM);
  endfunction

  function automatic logic uses_rs2(input logic [OPC_W-1:0] opc);
    return (opc == OPC_OP) || (opc == OPC_STORE) || (opc == OPC_BRANCH);
  endfunction

endpackage

// File: rtl/imm_gen.sv
// Combinational immediate generator: sign-extends the I/S/B/U/J immediate
// selected by the opcode; formats without an immediate yield zero.
module imm_gen
  import id_pkg::*;
(
  input  logic [XLEN-1:0] instr_i,
  output logic [XLEN-1:0] imm_o
);

  imm_fmt_e w_fmt;

  assign w_fmt = fmt_of(instr_i[OPC_W-1:0]);

  always_comb begin
    imm_o = '0;
    case (w_fmt)
      FMT_I: imm_o = {{20{instr_i[31]}}, instr_i[31:20]};
      FMT_S: imm_o = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
      FMT_B: imm_o = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                      instr_i[30:25], instr_i[11:8], 1'b0};
      FMT_U: imm_o = {instr_i[31:12], 12'b0};
      FMT_J: imm_o = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12],
                      instr_i[20], instr_i[30:21], 1'b0};
      default: imm_o = '0;
    endcase
  end

endmodule

// File: rtl/id_stage.sv
// Instruction-decode stage with load-use stall, execute redirect and a
// one-cycle KILL state. Define ID_EARLY_JAL_EN to redirect JAL from decode.
module id_stage
  import id_pkg::*;
#(
  parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [XLEN-1:0]   pc_i,
  input  logic [XLEN-1:0]   instr_i,
  input  logic              valid_i,
  output logic              stall_o,
  output logic              flush_o,
  output logic [XLEN-1:0]   pc_b_j_o,
  output logic              take_b_j_sig_o,
  input  logic              ex_ready_i,
  input  logic              ex_mem_read_i,
  input  logic [REG_W-1:0]  ex_rd_i,
  input  logic              ex_take_b_j_i,
  input  logic [XLEN-1:0]   ex_pc_b_j_i,
  output logic              valid_o,
  output logic [XLEN-1:0]   pc_o,
  output logic [XLEN-1:0]   instr_o,
  output logic [OPC_W-1:0]  opcode_o,
  output logic [F3_W-1:0]   funct3_o,
  output logic [F7_W-1:0]   funct7_o,
  output logic [REG_W-1:0]  rd_o,
  output logic [REG_W-1:0]  rs1_o,
  output logic [REG_W-1:0]  rs2_o,
  output logic [XLEN-1:0]   imm_o,
  output id_state_e         state_o
);

  // Handshake: fetch presents pc_i/instr_i while valid_i=1 and holds them while
  // stall_o=1; the decode register transfers to execute only when ex_ready_i=1,
  // otherwise it holds every field.

  id_state_e        r_state;
  dec_t             r_dec;
  dec_t             w_dec;
  dec_t             w_bubble;
  logic [XLEN-1:0]  w_imm;
  logic [XLEN-1:0]  w_jal_tgt;
  logic [OPC_W-1:0] w_opc;
  logic [REG_W-1:0] w_rs1;
  logic [REG_W-1:0] w_rs2;
  logic             w_run;
  logic             w_hazard;
  logic             w_early_jal;

  imm_gen u_imm_gen (
    .instr_i (instr_i),
    .imm_o   (w_imm)
  );

  assign w_opc = instr_i[6:0];
  assign w_rs1 = instr_i[19:15];
  assign w_rs2 = instr_i[24:20];
  assign w_run = (r_state == ST_RUN);

  assign w_hazard = w_run && valid_i && ex_mem_read_i && (ex_rd_i != '0) &&
                    ((uses_rs1(w_opc) && (ex_rd_i == w_rs1)) ||
                     (uses_rs2(w_opc) && (ex_rd_i == w_rs2)));

`ifdef ID_EARLY_JAL_EN
  assign w_early_jal = w_run && valid_i && (w_opc == OPC_JAL) && !w_hazard &&
                       ex_ready_i && !ex_take_b_j_i;
  assign w_jal_tgt   = pc_i + w_imm;
`else
  assign w_early_jal = 1'b0;
  assign w_jal_tgt   = '0;
`endif

  always_comb begin
    w_bubble       = '0;
    w_bubble.instr = NOP_INSTR;
  end

  always_comb begin
    w_dec        = '0;
    w_dec.valid  = 1'b1;
    w_dec.pc     = pc_i;
    w_dec.instr  = instr_i;
    w_dec.opcode = w_opc;
    w_dec.funct3 = instr_i[14:12];
    w_dec.funct7 = instr_i[31:25];
    w_dec.rd     = instr_i[11:7];
    w_dec.rs1    = w_rs1;
    w_dec.rs2    = w_rs2;
    w_dec.imm    = w_imm;
  end

  // Execute redirect outranks every other control; all strobes are masked in reset.
  always_comb begin
    take_b_j_sig_o = 1'b0;
    flush_o        = 1'b0;
    pc_b_j_o       = '0;
    stall_o        = 1'b0;
    if (!rst_i) begin
      if (ex_take_b_j_i) begin
        take_b_j_sig_o = 1'b1;
        flush_o        = 1'b1;
        pc_b_j_o       = ex_pc_b_j_i;
      end else begin
        stall_o = w_hazard || !ex_ready_i;
        if (w_early_jal) begin
          take_b_j_sig_o = 1'b1;
          flush_o        = 1'b1;
          pc_b_j_o       = w_jal_tgt;
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= ST_RUN;
      r_dec   <= w_bubble;
    end else if (ex_take_b_j_i) begin
      r_state <= ST_KILL;
      r_dec   <= w_bubble;
    end else begin
      r_state <= w_early_jal ? ST_KILL : ST_RUN;
      if (ex_ready_i) begin
        if (!w_run || w_hazard || !valid_i) begin
          r_dec <= w_bubble;
        end else begin
          r_dec <= w_dec;
        end
      end
    end
  end

  assign valid_o  = r_dec.valid;
  assign pc_o     = r_dec.pc;
  assign instr_o  = r_dec.instr;
  assign opcode_o = r_dec.opcode;
  assign funct3_o = r_dec.funct3;
  assign funct7_o = r_dec.funct7;
  assign rd_o     = r_dec.rd;
  assign rs1_o    = r_dec.rs1;
  assign rs2_o    = r_dec.rs2;
  assign imm_o    = r_dec.imm;
  assign state_o  = r_state;

endmodule

// File: tb/tb_id_stage.sv
// Directed self-checking bench for id_stage; expectations are hand-computed
// from the instruction encodings. Follows ID_EARLY_JAL_EN when defined.
module tb_id_stage;
  import id_pkg::*;

  logic              clk_i = 1'b0;
  logic              rst_i = 1'b0;
  logic [31:0]       pc_i = '0;
  logic [31:0]       instr_i = '0;
  logic              valid_i = 1'b0;
  logic              stall_o;
  logic              flush_o;
  logic [31:0]       pc_b_j_o;
  logic              take_b_j_sig_o;
  logic              ex_ready_i = 1'b0;
  logic              ex_mem_read_i = 1'b0;
  logic [4:0]        ex_rd_i = '0;
  logic              ex_take_b_j_i = 1'b0;
  logic [31:0]       ex_pc_b_j_i = '0;
  logic              valid_o;
  logic [31:0]       pc_o;
  logic [31:0]       instr_o;
  logic [6:0]        opcode_o;
  logic [2:0]        funct3_o;
  logic [6:0]        funct7_o;
  logic [4:0]        rd_o;
  logic [4:0]        rs1_o;
  logic [4:0]        rs2_o;
  logic [31:0]       imm_o;
  id_state_e         state_o;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];

  localparam logic [31:0] I_ADDI = 32'h00500093;  // addi x1, x0, 5
  localparam logic [31:0] I_ADD  = 32'h00108133;  // add  x2, x1, x1
  localparam logic [31:0] I_LUI  = 32'h123452B7;  // lui  x5, 0x12345
  localparam logic [31:0] I_SW   = 32'h00112223;  // sw   x1, 4(x2)
  localparam logic [31:0] I_BEQ  = 32'hFE000CE3;  // beq  x0, x0, -8
  localparam logic [31:0] I_JAL  = 32'h010000EF;  // jal  x1, +16

  id_stage dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .pc_i           (pc_i),
    .instr_i        (instr_i),
    .valid_i        (valid_i),
    .stall_o        (stall_o),
    .flush_o        (flush_o),
    .pc_b_j_o       (pc_b_j_o),
    .take_b_j_sig_o (take_b_j_sig_o),
    .ex_ready_i     (ex_ready_i),
    .ex_mem_read_i  (ex_mem_read_i),
    .ex_rd_i        (ex_rd_i),
    .ex_take_b_j_i  (ex_take_b_j_i),
    .ex_pc_b_j_i    (ex_pc_b_j_i),
    .valid_o        (valid_o),
    .pc_o           (pc_o),
    .instr_o        (instr_o),
    .opcode_o       (opcode_o),
    .funct3_o       (funct3_o),
    .funct7_o       (funct7_o),
    .rd_o           (rd_o),
    .rs1_o          (rs1_o),
    .rs2_o          (rs2_o),
    .imm_o          (imm_o),
    .state_o        (state_o)
  );

  // Clock / reset
  always #5 clk_i = ~clk_i;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, expv);
    end
  endtask

  task automatic drive(input logic [31:0] pc, input logic [31:0] instr, input logic vld);
    pc_i    = pc;
    instr_i = instr;
    valid_i = vld;
  endtask

  initial begin
    // Reset with a redirect and backpressure pending: strobes must stay masked.
    ex_take_b_j_i = 1'b1;
    ex_pc_b_j_i   = 32'h40;
    #1 rst_i = 1'b1;
    #2;
    chk("rst_valid", 32'(valid_o), 32'h0);
    chk("rst_instr", instr_o, 32'h00000013);
    chk("rst_pc", pc_o, 32'h0);
    chk("rst_imm", imm_o, 32'h0);
    chk("rst_stall", 32'(stall_o), 32'h0);
    chk("rst_flush", 32'(flush_o), 32'h0);
    chk("rst_take", 32'(take_b_j_sig_o), 32'h0);
    chk("rst_pcbj", pc_b_j_o, 32'h0);
    chk("rst_state", 32'(state_o), 32'(ST_RUN));
    step();
    rst_i = 1'b0;
    ex_take_b_j_i = 1'b0;
    ex_pc_b_j_i   = '0;
    ex_ready_i    = 1'b1;

    // Basic issue of addi
    drive(32'h0, I_ADDI, 1'b1);
    #1 chk("addi_stall", 32'(stall_o), 32'h0);
    step();
    chk("addi_valid", 32'(valid_o), 32'h1);
    chk("addi_pc", pc_o, 32'h0);
    chk("addi_rd", 32'(rd_o), 32'h1);
    chk("addi_rs1", 32'(rs1_o), 32'h0);
    chk("addi_imm", imm_o, 32'h5);
    chk("addi_opc", 32'(opcode_o), 32'h13);

    // Load-use hazard
    drive(32'h4, I_ADD, 1'b1);
    ex_mem_read_i = 1'b1;
    ex_rd_i = 5'd0;
    #1 chk("lu_x0_stall", 32'(stall_o), 32'h0);
    ex_rd_i = 5'd1;
    #1 chk("lu_stall", 32'(stall_o), 32'h1);
    step();
    chk("lu_bubble_valid", 32'(valid_o), 32'h0);
    chk("lu_bubble_instr", instr_o, 32'h00000013);
    ex_mem_read_i = 1'b0;
    #1 chk("lu_release_stall", 32'(stall_o), 32'h0);
    step();
    chk("add_valid", 32'(valid_o), 32'h1);
    chk("add_pc", pc_o, 32'h4);
    chk("add_rd", 32'(rd_o), 32'h2);
    chk("add_rs1", 32'(rs1_o), 32'h1);
    chk("add_rs2", 32'(rs2_o), 32'h1);
    chk("add_imm", imm_o, 32'h0);

    // LUI's rs1 field is not a real read, so no stall
    drive(32'h8, I_LUI, 1'b1);
    ex_mem_read_i = 1'b1;
    ex_rd_i = 5'd8;
    #1 chk("lui_no_haz", 32'(stall_o), 32'h0);
    step();
    ex_mem_read_i = 1'b0;
    chk("lui_imm", imm_o, 32'h12345000);
    chk("lui_rd", 32'(rd_o), 32'h5);

    // Backpressure for three cycles: everything holds
    drive(32'hC, I_SW, 1'b1);
    ex_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1 chk("bp_stall", 32'(stall_o), 32'h1);
      step();
      chk("bp_hold_valid", 32'(valid_o), 32'h1);
      chk("bp_hold_pc", pc_o, 32'h8);
      chk("bp_hold_instr", instr_o, I_LUI);
      chk("bp_hold_imm", imm_o, 32'h12345000);
    end
    ex_ready_i = 1'b1;
    #1 chk("bp_release_stall", 32'(stall_o), 32'h0);
    step();
    chk("sw_pc", pc_o, 32'hC);
    chk("sw_imm", imm_o, 32'h4);
    chk("sw_rs1", 32'(rs1_o), 32'h2);
    chk("sw_rs2", 32'(rs2_o), 32'h1);
    chk("sw_f3", 32'(funct3_o), 32'h2);

    // Execute redirect beats hazard and backpressure
    drive(32'h10, I_ADD, 1'b1);
    ex_mem_read_i = 1'b1;
    ex_rd_i       = 5'd1;
    ex_ready_i    = 1'b0;
    ex_take_b_j_i = 1'b1;
    ex_pc_b_j_i   = 32'h40;
    #1;
    chk("redir_take", 32'(take_b_j_sig_o), 32'h1);
    chk("redir_flush", 32'(flush_o), 32'h1);
    chk("redir_pcbj", pc_b_j_o, 32'h40);
    chk("redir_stall", 32'(stall_o), 32'h0);
    step();
    chk("redir_valid0", 32'(valid_o), 32'h0);
    chk("redir_instr", instr_o, 32'h00000013);
    chk("redir_state", 32'(state_o), 32'(ST_KILL));
    ex_take_b_j_i = 1'b0;
    ex_pc_b_j_i   = '0;
    ex_mem_read_i = 1'b0;
    ex_ready_i    = 1'b1;
    drive(32'h14, I_ADDI, 1'b1);
    #1;
    chk("kill_take", 32'(take_b_j_sig_o), 32'h0);
    chk("kill_flush", 32'(flush_o), 32'h0);
    chk("kill_pcbj", pc_b_j_o, 32'h0);
    step();
    chk("kill_valid0", 32'(valid_o), 32'h0);
    chk("kill_state", 32'(state_o), 32'(ST_RUN));
    drive(32'h40, I_ADDI, 1'b1);
    step();
    chk("post_kill_valid", 32'(valid_o), 32'h1);
    chk("post_kill_pc", pc_o, 32'h40);

    // Negative B-type immediate
    drive(32'h44, I_BEQ, 1'b1);
    step();
    chk("beq_imm", imm_o, 32'hFFFFFFF8);
    chk("beq_opc", 32'(opcode_o), 32'h63);

    // Back-to-back stream through the scoreboard
    for (int i = 1; i <= 4; i++) begin
      drive(32'h100 + 32'(4 * i), (32'(i * 3) << 20) | (32'(i) << 7) | 32'h13, 1'b1);
      exp_q.push_back(32'h100 + 32'(4 * i));
      step();
      chk("stream_pc", pc_o, exp_q.pop_front());
      chk("stream_rd", 32'(rd_o), 32'(i));
      chk("stream_imm", imm_o, 32'(i * 3));
    end

    // JAL: early redirect only when the feature is built in
    drive(32'h8, I_JAL, 1'b1);
    #1;
`ifdef ID_EARLY_JAL_EN
    chk("jal_take", 32'(take_b_j_sig_o), 32'h1);
    chk("jal_flush", 32'(flush_o), 32'h1);
    chk("jal_pcbj", pc_b_j_o, 32'h18);
`else
    chk("jal_take", 32'(take_b_j_sig_o), 32'h0);
    chk("jal_pcbj", pc_b_j_o, 32'h0);
`endif
    step();
    chk("jal_valid", 32'(valid_o), 32'h1);
    chk("jal_rd", 32'(rd_o), 32'h1);
    chk("jal_pc", pc_o, 32'h8);
    chk("jal_imm", imm_o, 32'h10);
`ifdef ID_EARLY_JAL_EN
    chk("jal_state", 32'(state_o), 32'(ST_KILL));
`else
    chk("jal_state", 32'(state_o), 32'(ST_RUN));
`endif
    drive(32'h0, 32'h0, 1'b0);
    step();

    // JAL at the top of the address space wraps
    drive(32'hFFFFFFFC, I_JAL, 1'b1);
    #1;
`ifdef ID_EARLY_JAL_EN
    chk("wrap_pcbj", pc_b_j_o, 32'h0000000C);
`else
    chk("wrap_take", 32'(take_b_j_sig_o), 32'h0);
`endif
    step();
    chk("wrap_pc", pc_o, 32'hFFFFFFFC);
    drive(32'h200, I_ADDI, 1'b1);
    step();
    step();
    chk("pre_rst_valid", 32'(valid_o), 32'h1);

    // Asynchronous reset mid-stream, between clock edges
    ex_ready_i = 1'b0;
    #2 rst_i = 1'b1;
    #1;
    chk("arst_valid", 32'(valid_o), 32'h0);
    chk("arst_instr", instr_o, 32'h00000013);
    chk("arst_stall", 32'(stall_o), 32'h0);
    #1 rst_i = 1'b0;
    ex_ready_i = 1'b1;

    // Reset during KILL returns straight to RUN
    ex_take_b_j_i = 1'b1;
    ex_pc_b_j_i   = 32'h80;
    step();
    ex_take_b_j_i = 1'b0;
    ex_pc_b_j_i   = '0;
    chk("kill_before_rst", 32'(state_o), 32'(ST_KILL));
    #2 rst_i = 1'b1;
    #1 chk("rst_kill_state", 32'(state_o), 32'(ST_RUN));
    #1 rst_i = 1'b0;
    drive(32'h300, I_ADDI, 1'b1);
    step();
    chk("rst_kill_issue", 32'(valid_o), 32'h1);
    chk("rst_kill_pc", pc_o, 32'h300);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
